// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the I2C byte-level master sequencer.
package i2c_ctrl_pkg;

    // Sequencer states; HOLD keeps SCL low between bytes without a STOP.
    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        HOLD
    } state_e;

    // Quarter-bit phase numbers within every START/BIT/ACK/STOP slot.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // 100 MHz / 250 = 400 kHz quarter-bit tick -> 100 kHz SCL.
    localparam int unsigned CLK_DIV_DEF = 250;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-bit tick divider: counts 0..CLK_DIV-1 while enabled and pulses
// tick for one cycle on the wrap. clr restarts the count from zero.
module i2c_qtick #(
    parameter int unsigned CLK_DIV = 250,
    parameter int unsigned DIV_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;

    assign tick = en && !clr && (cnt_q == LAST);

    // Divider counter; a clear wins over counting so the next tick lands
    // exactly CLK_DIV cycles after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master sequencer: START / 8 data bits / ACK / STOP driven
// as open-drain enables on a four-phase-per-bit schedule.
// Optional build macro I2C_MASTER_CTRL_CLK_STRETCH_EN: wait for SCL to read
// high after every release before continuing (slave clock stretching).
module i2c_master_ctrl
    import i2c_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned DIV_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_mack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    state_e     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] bit_q,   bit_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rdata_q, rdata_d;
    logic       nack_q,  nack_d;
    logic       rvld_q,  rvld_d;
    logic       stop_q,  stop_d;
    logic       read_q,  read_d;
    logic       mack_q,  mack_d;
    logic [7:0] wdata_q, wdata_d;
    logic       init_q;
    logic       accept;
    logic       tick;
    logic       tick_fsm;
    logic       div_clr;
    logic       parked;

    assign parked    = (state_q == IDLE) || (state_q == HOLD);
    assign cmd_ready = init_q && parked && !rvld_q;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = !parked;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign rsp_valid = rvld_q;
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = nack_q;

`ifdef I2C_MASTER_CTRL_CLK_STRETCH_EN
    logic str_q, str_d;
    // While waiting for the slave to release SCL the divider is held at zero,
    // so timing restarts from the moment the release is seen.
    assign tick_fsm = tick && !str_q;
    assign div_clr  = accept || str_q;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign tick_fsm   = tick;
    assign div_clr    = accept;
`endif

    i2c_qtick #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_qtick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (div_clr),
        .tick  (tick)
    );

    // Next-state and output-register logic: command capture on accept,
    // otherwise one phase action per quarter-bit tick.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
        shift_d  = shift_q;
        rdata_d  = rdata_q;
        nack_d   = nack_q;
        rvld_d   = 1'b0;
        stop_d   = stop_q;
        read_d   = read_q;
        mack_d   = mack_q;
        wdata_d  = wdata_q;
`ifdef I2C_MASTER_CTRL_CLK_STRETCH_EN
        str_d    = str_q && !scl_i;
`endif
        if (accept) begin
            stop_d  = cmd_stop;
            read_d  = cmd_read;
            mack_d  = cmd_mack;
            wdata_d = cmd_wdata;
            phase_d = Q0;
            bit_d   = 3'd7;
            // A byte never goes out on a free bus without a START first.
            state_d = (cmd_start || state_q == IDLE) ? START : BIT;
        end else if (tick_fsm) begin
            phase_d = phase_q + 2'd1;
`ifdef I2C_MASTER_CTRL_CLK_STRETCH_EN
            if (phase_q == Q1 && !parked) str_d = 1'b1;
`endif
            case (state_q)
                START: begin
                    case (phase_q)
                        Q0: sda_oe_d = 1'b0;
                        Q1: scl_oe_d = 1'b0;
                        Q2: sda_oe_d = 1'b1;
                        default: begin
                            scl_oe_d = 1'b1;
                            bit_d    = 3'd7;
                            state_d  = BIT;
                        end
                    endcase
                end
                BIT: begin
                    case (phase_q)
                        Q0: sda_oe_d = read_q ? 1'b0 : ~wdata_q[bit_q];
                        Q1: scl_oe_d = 1'b0;
                        Q2: if (read_q) shift_d = {shift_q[6:0], sda_i};
                        default: begin
                            scl_oe_d = 1'b1;
                            if (bit_q == 3'd0) state_d = ACK;
                            else               bit_d   = bit_q - 3'd1;
                        end
                    endcase
                end
                ACK: begin
                    case (phase_q)
                        Q0: sda_oe_d = read_q && mack_q;
                        Q1: scl_oe_d = 1'b0;
                        Q2: nack_d   = read_q ? 1'b0 : sda_i;
                        default: begin
                            scl_oe_d = 1'b1;
                            rvld_d   = 1'b1;
                            if (read_q) rdata_d = shift_q;
                            state_d  = stop_q ? STOP : HOLD;
                        end
                    endcase
                end
                STOP: begin
                    case (phase_q)
                        Q0: sda_oe_d = 1'b1;
                        Q1: scl_oe_d = 1'b0;
                        Q2: sda_oe_d = 1'b0;
                        default: state_d = IDLE;
                    endcase
                end
                default: phase_d = phase_q;
            endcase
        end
    end

    // State and output registers; reset releases both lines at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= Q0;
            bit_q    <= 3'd7;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            shift_q  <= '0;
            rdata_q  <= '0;
            nack_q   <= 1'b0;
            rvld_q   <= 1'b0;
            stop_q   <= 1'b0;
            read_q   <= 1'b0;
            mack_q   <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            shift_q  <= shift_d;
            rdata_q  <= rdata_d;
            nack_q   <= nack_d;
            rvld_q   <= rvld_d;
            stop_q   <= stop_d;
            read_q   <= read_d;
            mack_q   <= mack_d;
            wdata_q  <= wdata_d;
        end
    end

    // cmd_ready stays low on the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_q <= 1'b0;
        else        init_q <= 1'b1;
    end

`ifdef I2C_MASTER_CTRL_CLK_STRETCH_EN
    // Stretch-wait flag: set after SCL is released, cleared once SCL reads high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) str_q <= 1'b0;
        else        str_q <= str_d;
    end
`endif

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with CLK_DIV=4 and a small bus-level
// slave/monitor that decodes START/STOP and the bits seen at SCL rise.
module tb_i2c_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       cmd_read = 1'b0;
    logic       cmd_mack = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
    logic [7:0] rsp_rdata;
    logic       scl_i, sda_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(4), .DIV_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .cmd_read  (cmd_read),
        .cmd_wdata (cmd_wdata),
        .cmd_mack  (cmd_mack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_i     (scl_i),
        .sda_i     (sda_i)
    );

    // Slave model: w = bit window (-1 after START, 0..7 data, 8 = ACK slot).
    logic       slave_read = 1'b0;
    logic       slave_ack  = 1'b1;
    logic [7:0] slave_byte = 8'h96;
    int         w = -1;
    logic       slave_pull;

    always_comb begin
        slave_pull = 1'b0;
        if (slave_read && w >= 0 && w <= 7) slave_pull = ~slave_byte[3'(7 - w)];
        else if (!slave_read && w == 8)     slave_pull = slave_ack;
    end

    assign scl_i = ~scl_oe;
    assign sda_i = ~(sda_oe | slave_pull);

    int         start_cnt = 0, stop_cnt = 0, rsp_cnt = 0, acc_cnt = 0;
    logic [7:0] cap = 8'h00, byte_seen = 8'h00;
    logic       ack_seen = 1'b0;
    logic       pscl = 1'b1, psda = 1'b1;

    always @(negedge clk) begin
        if (pscl && scl_i && psda && !sda_i) begin
            start_cnt <= start_cnt + 1;
            w <= -1;
        end else if (pscl && scl_i && !psda && sda_i) begin
            stop_cnt <= stop_cnt + 1;
        end
        if (pscl && !scl_i) w <= (w == 8) ? 0 : w + 1;
        if (!pscl && scl_i) begin
            if (w >= 0 && w <= 7) cap <= {cap[6:0], sda_i};
            else if (w == 8) begin
                byte_seen <= cap;
                ack_seen  <= sda_i;
            end
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        pscl <= scl_i;
        psda <= sda_i;
    end

    always @(posedge clk) if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic st, input logic sp, input logic rd,
                         input logic [7:0] wd, input logic mk);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_wdata = wd; cmd_mack = mk;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("accept", ok, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk(tag, ok, 1);
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        chk(tag, ok, 1);
        repeat (2) @(negedge clk);
    endtask

    int  s0, p0, r0, a0;
    logic ok;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rvld", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_nack", rsp_nack, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);

        // T1: write 0xA5 with START+STOP, slave ACKs
        s0 = start_cnt; p0 = stop_cnt; r0 = rsp_cnt; slave_ack = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
        wait_rsp("t1_rsp");
        chk("t1_nack", rsp_nack, 0);
        chk("t1_busy_in_stop", busy, 1);
        wait_idle("t1_idle");
        chk("t1_byte", byte_seen, 8'hA5);
        chk("t1_ack_line", ack_seen, 0);
        chk("t1_starts", start_cnt, s0 + 1);
        chk("t1_stops", stop_cnt, p0 + 1);
        chk("t1_rsp_once", rsp_cnt, r0 + 1);
        chk("t1_scl_rel", scl_oe, 0);
        chk("t1_sda_rel", sda_oe, 0);
        chk("t1_ready", cmd_ready, 1);

        // T2: write 0x3C, slave NACKs, no STOP; cmd_valid held throughout
        a0 = acc_cnt; r0 = rsp_cnt; p0 = stop_cnt; slave_ack = 1'b0;
        @(negedge clk);
        cmd_start = 1'b1; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_wdata = 8'h3C;
        cmd_valid = 1'b1;
        @(negedge clk);
        wait_rsp("t2_rsp");
        chk("t2_ready_on_rsp", cmd_ready, 0);
        chk("t2_nack", rsp_nack, 1);
        chk("t2_scl_held", scl_oe, 1);
        chk("t2_busy", busy, 0);
        @(negedge clk);
        chk("t2_ready_after", cmd_ready, 1);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2_one_accept", acc_cnt, a0 + 1);
        chk("t2_byte", byte_seen, 8'h3C);
        chk("t2_ack_line", ack_seen, 1);
        chk("t2_no_stop", stop_cnt, p0);
        chk("t2_rsp_once", rsp_cnt, r0 + 1);
        chk("t2_hold_scl", scl_oe, 1);

        // T3: from HOLD without START, write 0x0F, stay in HOLD
        s0 = start_cnt; p0 = stop_cnt; slave_ack = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 8'h0F, 1'b0);
        wait_rsp("t3_rsp");
        chk("t3_nack", rsp_nack, 0);
        repeat (2) @(negedge clk);
        chk("t3_no_start", start_cnt, s0);
        chk("t3_no_stop", stop_cnt, p0);
        chk("t3_byte", byte_seen, 8'h0F);
        chk("t3_hold_scl", scl_oe, 1);

        // T4: repeated START from HOLD, write 0x55, STOP
        s0 = start_cnt; p0 = stop_cnt;
        issue(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
        wait_rsp("t4_rsp");
        chk("t4_rstart", start_cnt, s0 + 1);
        chk("t4_no_stop_between", stop_cnt, p0);
        wait_idle("t4_idle");
        chk("t4_byte", byte_seen, 8'h55);
        chk("t4_stop", stop_cnt, p0 + 1);

        // T5: read 0x96 with master NACK and STOP
        slave_read = 1'b1; slave_byte = 8'h96;
        s0 = start_cnt; p0 = stop_cnt;
        issue(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        wait_rsp("t5_rsp");
        chk("t5_rdata", rsp_rdata, 8'h96);
        chk("t5_nack", rsp_nack, 0);
        chk("t5_sda_ack", sda_oe, 0);
        wait_idle("t5_idle");
        chk("t5_ack_line", ack_seen, 1);
        chk("t5_start", start_cnt, s0 + 1);
        chk("t5_stop", stop_cnt, p0 + 1);
        slave_read = 1'b0;

        // T6: reset during bit 4 of 0xE7 (bit 4 = 0 so SDA is pulled)
        issue(1'b1, 1'b1, 1'b0, 8'hE7, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (w == 3) begin ok = 1'b1; break; end
        end
        chk("t6_reach_bit4", ok, 1);
        repeat (5) @(negedge clk);
        chk("t6_pre_scl", scl_oe, 1);
        chk("t6_pre_sda", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_scl_rel", scl_oe, 0);
        chk("t6_sda_rel", sda_oe, 0);
        chk("t6_busy", busy, 0);
        chk("t6_rdata_clr", rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T7: first command after reset without cmd_start still gets a START
        s0 = start_cnt; p0 = stop_cnt;
        issue(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);
        wait_rsp("t7_rsp");
        chk("t7_nack", rsp_nack, 0);
        wait_idle("t7_idle");
        chk("t7_start", start_cnt, s0 + 1);
        chk("t7_byte", byte_seen, 8'h5A);
        chk("t7_stop", stop_cnt, p0 + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
